// File: rtl/apb_port_router_pkg.sv
// Shared types and default sizing for the APB port router.
package apb_router_pkg;

  localparam int NUM_PORTS_DEF = 6;
  localparam int PORT_BASE_DEF = 2;
  localparam int TIMEOUT_DEF   = 16;
  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 32;
  localparam int SEL_W_DEF     = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR    = 3'd3,
    WAIT   = 3'd4
  } state_e;

endpackage

// File: rtl/apb_port_router_if.sv
// Request side and fanned-out APB peripheral side of the router in one bundle.
// Handshake: the master raises en and keeps it high until it sees the single-cycle
// ready pulse; slverr/rdata_out are valid with ready and hold until the next
// completion. en must drop before another transfer is started.
interface apb_port_router_if
  import apb_router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SEL_W     = SEL_W_DEF
);

  logic                        en;
  logic                        wr_in;
  logic [SEL_W-1:0]            sel_port;
  logic [ADDR_W-1:0]           addr_in;
  logic [DATA_W-1:0]           data_in;
  logic                        ready;
  logic                        slverr;
  logic [DATA_W-1:0]           rdata_out;
  logic [NUM_PORTS-1:0]        psel;
  logic                        penable;
  logic [NUM_PORTS-1:0]        pwrite;
  logic [NUM_PORTS*ADDR_W-1:0] paddr;
  logic [NUM_PORTS*DATA_W-1:0] pwdata;
  logic [NUM_PORTS*DATA_W-1:0] prdata;
  logic [NUM_PORTS-1:0]        pready;

  modport master (
    output en, wr_in, sel_port, addr_in, data_in, prdata, pready,
    input  ready, slverr, rdata_out, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    input  en, wr_in, sel_port, addr_in, data_in, prdata, pready,
    output ready, slverr, rdata_out, psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_port_router_decode.sv
// Maps a port code to a one-hot port vector; valid is low for codes outside the port window.
module apb_port_decode #(
  parameter int NUM_PORTS = 6,
  parameter int SEL_W     = 3,
  parameter int PORT_BASE = 2
) (
  input  logic [SEL_W-1:0]     sel_port_i,
  output logic [NUM_PORTS-1:0] onehot_o,
  output logic                 valid_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      onehot_o[i] = (int'(sel_port_i) == (PORT_BASE + i));
    end
    valid_o = |onehot_o;
  end

endmodule

// File: rtl/apb_port_router.sv
// Single-master APB bridge that routes each transfer to one of NUM_PORTS peripherals,
// with an access timeout and an error response for unmapped port codes.
module apb_port_router
  import apb_router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter int PORT_BASE = PORT_BASE_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  apb_port_router_if.slave  bus,
  output state_e            state_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                      state_q;
  logic                        wr_q;
  logic [SEL_W-1:0]            sel_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [DATA_W-1:0]           wdata_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        ready_q;
  logic                        slverr_q;
  logic [DATA_W-1:0]           rdata_q;
  logic [NUM_PORTS-1:0]        psel_q;
  logic                        penable_q;
  logic [NUM_PORTS-1:0]        pwrite_q;
  logic [NUM_PORTS*ADDR_W-1:0] paddr_q;
  logic [NUM_PORTS*DATA_W-1:0] pwdata_q;

  logic [NUM_PORTS-1:0]        dec_onehot;
  logic                        dec_valid;
  logic                        sel_pready;
  logic [DATA_W-1:0]           sel_prdata;
  logic [NUM_PORTS*ADDR_W-1:0] paddr_d;
  logic [NUM_PORTS*DATA_W-1:0] pwdata_d;
  logic                        timeout_hit;

  apb_port_decode #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W),
    .PORT_BASE (PORT_BASE)
  ) u_decode (
    .sel_port_i (sel_q),
    .onehot_o   (dec_onehot),
    .valid_o    (dec_valid)
  );

  // psel_q is one-hot during a transfer, so masking isolates the selected port.
  always_comb begin
    sel_pready = |(bus.pready & psel_q);
    sel_prdata = '0;
    paddr_d    = '0;
    pwdata_d   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (psel_q[i]) sel_prdata = sel_prdata | bus.prdata[i*DATA_W +: DATA_W];
      if (dec_onehot[i]) begin
        paddr_d[i*ADDR_W +: ADDR_W]  = addr_q;
        pwdata_d[i*DATA_W +: DATA_W] = wdata_q;
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      slverr_q  <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            wr_q    <= bus.wr_in;
            sel_q   <= bus.sel_port;
            addr_q  <= bus.addr_in;
            wdata_q <= bus.data_in;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q     <= '0;
          penable_q <= 1'b0;
          if (dec_valid) begin
            psel_q   <= dec_onehot;
            pwrite_q <= wr_q ? dec_onehot : '0;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            state_q  <= ACCESS;
          end else begin
            psel_q   <= '0;
            pwrite_q <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            ready_q  <= 1'b1;
            slverr_q <= 1'b1;
            rdata_q  <= '0;
            state_q  <= ERR;
          end
        end
        ACCESS: begin
          // First ACCESS cycle is the APB setup phase; pready is only sampled once penable is up.
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (sel_pready) begin
            ready_q   <= 1'b1;
            slverr_q  <= 1'b0;
            rdata_q   <= wr_q ? '0 : sel_prdata;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= '0;
            state_q   <= WAIT;
          end else if (timeout_hit) begin
            ready_q   <= 1'b1;
            slverr_q  <= 1'b1;
            rdata_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= '0;
            state_q   <= WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ERR: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (!bus.en) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.slverr    = slverr_q;
  assign bus.rdata_out = rdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_apb_port_router.sv
// Directed bench for apb_port_router: a vector table of single transfers plus
// hand-written sequences for held en, early en release and mid-transfer reset.
module tb_apb_port_router;
  import apb_router_pkg::*;

  localparam int NP = 6;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 3;

  logic   clk;
  logic   rst;
  state_e state;

  apb_port_router_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

  apb_port_router dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] prdata;
    int          wait_n;
    int          port;
    logic [5:0]  exp_psel;
    int          exp_lat;
    int          exp_pen;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   bus.ready,     1'b0);
    check({tag, "_slverr"},  bus.slverr,    1'b0);
    check({tag, "_rdata"},   bus.rdata_out, '0);
    check({tag, "_psel"},    bus.psel,      '0);
    check({tag, "_penable"}, bus.penable,   1'b0);
    check({tag, "_pwrite"},  bus.pwrite,    '0);
    check({tag, "_paddr"},   bus.paddr,     '0);
    check({tag, "_pwdata"},  bus.pwdata,    '0);
    check({tag, "_state"},   state,         IDLE);
  endtask

  // Runs one transfer from IDLE; drop_early releases en right after it is latched.
  task automatic run_vec(input string tag, input vec_t v, input bit drop_early);
    int          k;
    int          pen_cnt;
    bit          done;
    bit          cap;
    logic [5:0]  psel_or;
    logic [5:0]  pwrite_cap;
    logic [71:0] paddr_cap;
    logic [191:0] pwdata_cap;
    logic [5:0]  exp_pwrite;
    logic [71:0] exp_paddr;
    logic [191:0] exp_pwdata;
    logic        err_seen;
    logic [31:0] rdata_seen;

    exp_pwrite = '0;
    exp_paddr  = '0;
    exp_pwdata = '0;
    if (v.port >= 0) begin
      exp_pwrite[v.port]           = v.wr;
      exp_paddr[v.port*AW +: AW]   = v.addr;
      exp_pwdata[v.port*DW +: DW]  = v.data;
    end

    for (int i = 0; i < NP; i++)
      bus.prdata[i*DW +: DW] = (i == v.port) ? v.prdata : (32'hBAD0_0000 | 32'(i));
    bus.pready = '1;
    if (v.port >= 0) bus.pready[v.port] = (v.wait_n == 0);
    bus.en       = 1'b1;
    bus.wr_in    = v.wr;
    bus.sel_port = v.sel;
    bus.addr_in  = v.addr;
    bus.data_in  = v.data;

    k = -1; pen_cnt = 0; done = 0; cap = 0;
    psel_or = '0; pwrite_cap = '0; paddr_cap = '0; pwdata_cap = '0;
    err_seen = 1'b0; rdata_seen = '0;
    while (!done && k < 60) begin
      tick();
      k++;
      if (k == 0) begin
        bus.wr_in    = ~v.wr;
        bus.sel_port = 3'($urandom_range(0, 7));
        bus.addr_in  = 12'($urandom);
        bus.data_in  = $urandom;
        if (drop_early) bus.en = 1'b0;
      end
      if (bus.penable) pen_cnt++;
      psel_or = psel_or | bus.psel;
      if (!cap && bus.psel != '0) begin
        cap        = 1;
        pwrite_cap = bus.pwrite;
        paddr_cap  = bus.paddr;
        pwdata_cap = bus.pwdata;
      end
      if (bus.ready) begin
        done       = 1;
        err_seen   = bus.slverr;
        rdata_seen = bus.rdata_out;
        check({tag, "_state_at_ready"}, state, (v.port >= 0) ? WAIT : ERR);
      end else if (v.port >= 0) begin
        bus.pready[v.port] = (v.wait_n == 0) || (pen_cnt > v.wait_n);
      end
    end

    check({tag, "_done"},    done,     1'b1);
    check({tag, "_latency"}, k,        v.exp_lat);
    check({tag, "_psel"},    psel_or,  v.exp_psel);
    check({tag, "_pen_cyc"}, pen_cnt,  v.exp_pen);
    check({tag, "_slverr"},  err_seen, v.exp_err);
    check({tag, "_rdata"},   rdata_seen, v.exp_rdata);
    if (v.port >= 0) begin
      check({tag, "_pwrite"}, pwrite_cap, exp_pwrite);
      check({tag, "_paddr"},  paddr_cap,  exp_paddr);
      check({tag, "_pwdata"}, pwdata_cap, exp_pwdata);
    end

    bus.en = 1'b0;
    tick();
    check({tag, "_ready_1cyc"}, bus.ready,     1'b0);
    check({tag, "_err_hold"},   bus.slverr,    v.exp_err);
    check({tag, "_rd_hold"},    bus.rdata_out, v.exp_rdata);
    check({tag, "_state_post"}, state, (v.port >= 0) ? IDLE : WAIT);
    check({tag, "_psel_clr"},   bus.psel,      '0);
    tick();
    check({tag, "_state_idle"}, state, IDLE);
    bus.pready = '1;
  endtask

  initial begin
    int   pulses;
    int   guard;
    vec_t v;

    //          wr    sel   addr     data          prdata        wait port psel       lat pen err rdata
    vecs[0] = '{1'b0, 3'd7, 12'h3F0, 32'h0,        32'h12345678, 4,   5,  6'b100000, 7,  5,  1'b0, 32'h12345678};
    vecs[1] = '{1'b1, 3'd3, 12'h0A4, 32'hDEADBEEF, 32'h55555555, 0,   1,  6'b000010, 3,  1,  1'b0, 32'h0};
    vecs[2] = '{1'b0, 3'd1, 12'h111, 32'h0,        32'h77777777, 0,   -1, 6'b000000, 1,  0,  1'b1, 32'h0};
    vecs[3] = '{1'b0, 3'd4, 12'h802, 32'h0,        32'hCAFEF00D, 2,   2,  6'b000100, 5,  3,  1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 3'd2, 12'hFFF, 32'h0,        32'h99999999, 100, 0,  6'b000001, 18, 16, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 3'd6, 12'h5A5, 32'h0,        32'hA5A55A5A, 0,   4,  6'b010000, 3,  1,  1'b0, 32'hA5A55A5A};
    vecs[6] = '{1'b1, 3'd0, 12'h001, 32'h01234567, 32'h0,        0,   -1, 6'b000000, 1,  0,  1'b1, 32'h0};

    rst = 1'b1;
    bus.en = 1'b0; bus.wr_in = 1'b0; bus.sel_port = '0;
    bus.addr_in = '0; bus.data_in = '0; bus.prdata = '0; bus.pready = '1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle_no_en");

    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

    // en held high for 20 cycles yields exactly one transfer.
    for (int i = 0; i < NP; i++) bus.prdata[i*DW +: DW] = 32'h0BAD_CAFE;
    bus.pready = '1;
    bus.en = 1'b1; bus.wr_in = 1'b0; bus.sel_port = 3'd5; bus.addr_in = 12'h050;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ready) pulses++;
    end
    check("held_en_pulses", pulses, 1);
    check("held_en_state",  state,  WAIT);
    check("held_en_rdata",  bus.rdata_out, 32'h0BAD_CAFE);
    bus.en = 1'b0;
    tick();
    check("held_en_release", state, IDLE);
    run_vec("after_held", vecs[5], 1'b0);

    // en dropped right after the latch: the transfer still completes.
    run_vec("drop_early", vecs[3], 1'b1);

    // Reset asserted while ACCESS is waiting on a stalled port.
    bus.pready = '1;
    bus.pready[0] = 1'b0;
    bus.en = 1'b1; bus.wr_in = 1'b1; bus.sel_port = 3'd2;
    bus.addr_in = 12'h123; bus.data_in = 32'h87654321;
    guard = 0;
    while (!bus.penable && guard < 20) begin
      tick();
      guard++;
    end
    check("rst_mid_reached_access", bus.penable, 1'b1);
    tick();
    rst = 1'b1;
    bus.en = 1'b0;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ready) pulses++;
    end
    check("rst_mid_no_ready", pulses, 0);
    bus.pready = '1;
    run_vec("after_rst", vecs[1], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_port_router.md
APB_PORT_ROUTER -- requirements
Module: apb_port_router

Interface
REQ-001 Parameter NUM_PORTS, default 6: number of peripheral ports, range 1..(2**SEL_W - PORT_BASE).
REQ-002 Parameter ADDR_W, default 12: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter SEL_W, default 3: sel_port width.
REQ-005 Parameter PORT_BASE, default 2: sel_port code of port 0. Port i is selected when sel_port == PORT_BASE+i.
REQ-006 Parameter TIMEOUT, default 16: ACCESS cycles allowed before error. 0 disables the timeout.
REQ-007 clk  in  1  sole clock, all logic on posedge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 en  in  1  transfer request from the APB master.
REQ-010 wr_in  in  1  1 = write, 0 = read.
REQ-011 sel_port  in  SEL_W  target port code.
REQ-012 addr_in  in  ADDR_W  transfer address.
REQ-013 data_in  in  DATA_W  write data.
REQ-014 ready  out  1  one-cycle transfer-complete pulse.
REQ-015 slverr  out  1  error flag, valid with ready.
REQ-016 rdata_out  out  DATA_W  read data, valid with ready.
REQ-017 psel  out  NUM_PORTS  one-hot peripheral select.
REQ-018 penable  out  1  APB access phase, shared by all ports.
REQ-019 pwrite  out  NUM_PORTS  per-port write strobe.
REQ-020 paddr  out  NUM_PORTS*ADDR_W  flattened per-port address. Port i occupies slice [i*ADDR_W +: ADDR_W].
REQ-021 pwdata  out  NUM_PORTS*DATA_W  flattened per-port write data.
REQ-022 prdata  in  NUM_PORTS*DATA_W  flattened per-port read data.
REQ-023 pready  in  NUM_PORTS  per-port peripheral ready.

Function
REQ-024 The FSM SHALL have states IDLE, SETUP, ACCESS, ERR and WAIT, and all outputs SHALL be registered.
REQ-025 In IDLE, when en=1 the FSM SHALL latch wr_in, sel_port, addr_in and data_in, then go to SETUP. Otherwise it SHALL stay in IDLE.
REQ-026 In SETUP with a valid port:
 - psel[i]=1, penable=0;
 - pwrite[i], paddr slice i and pwdata slice i driven from the latched values;
 - all other ports' psel, pwrite, paddr and pwdata slices driven to 0;
 - next state ACCESS.
REQ-027 In SETUP with an invalid port (sel_port < PORT_BASE or sel_port >= PORT_BASE+NUM_PORTS): no psel asserted, next state ERR.
REQ-028 In ACCESS: penable=1. Only pready[i] of the selected port is sampled; pready of unselected ports is ignored.
REQ-029 On pready[i]=1 in ACCESS:
 - next cycle: ready=1 and slverr=0;
 - for a read, rdata_out = prdata slice i; for a write, rdata_out=0;
 - psel, penable and pwrite cleared;
 - next state WAIT.
REQ-030 ACCESS timeout: a counter of width $clog2(TIMEOUT+1) SHALL count ACCESS cycles. If it reaches TIMEOUT with pready[i] still 0 (TIMEOUT>0), the next cycle SHALL give ready=1, slverr=1, rdata_out=0, psel and penable cleared, and state WAIT.
REQ-031 ERR SHALL last one cycle and give ready=1, slverr=1, rdata_out=0, then go to WAIT.
REQ-032 ready SHALL be high for exactly one cycle per transfer.
REQ-033 slverr and rdata_out SHALL hold their values until the next transfer completes.
REQ-034 WAIT SHALL go to IDLE when en=0 and stay in WAIT while en=1, so one en assertion yields exactly one transfer.
REQ-035 Deasserting en during SETUP or ACCESS SHALL NOT abort the transfer: it completes normally and WAIT then exits immediately.
REQ-036 Latency for a valid port with zero-wait pready: en sampled at edge 0, psel at edge 1, penable at edge 2, ready high after edge 3.
REQ-037 Input changes after the IDLE latch SHALL NOT affect the transfer in flight.

Reset
REQ-038 rst=1 at a posedge SHALL force state IDLE and clear the timeout counter.
REQ-039 rst=1 at a posedge SHALL zero every output: ready, slverr, rdata_out, psel, penable, pwrite, paddr, pwdata.
REQ-040 Reset asserted mid-transfer SHALL abandon the transfer with no ready pulse, and the clean state SHALL be visible one cycle after the rst edge.

Structure
REQ-041 Package apb_router_pkg SHALL hold the FSM state enum and the default parameter values (NUM_PORTS, PORT_BASE, TIMEOUT).
REQ-042 Sub-module apb_port_decode SHALL be combinational: it maps sel_port to a one-hot vector plus a valid flag.
REQ-043 No other sub-modules SHALL be used.

Verification
REQ-044 Write, sel_port=3, addr=0x0A4, data=0xDEADBEEF, pready[1] tied to 1 -> psel=6'b000010, pwrite[1]=1, paddr slice 1=0x0A4, pwdata slice 1=0xDEADBEEF, ready pulse 3 cycles after en, slverr=0.
REQ-045 Read, sel_port=7, prdata slice 5=0x12345678, pready[5] raised after 4 ACCESS cycles -> rdata_out=0x12345678 with ready, penable high for 5 cycles.
REQ-046 sel_port=1 (invalid) -> no psel asserted, one-cycle ready with slverr=1, rdata_out=0.
REQ-047 TIMEOUT=16, selected pready held 0 -> ready with slverr=1 after 16 ACCESS cycles, psel cleared, pready of other ports ignored.
REQ-048 en held high for 20 cycles -> exactly one ready pulse; after en drops, next en starts a new transfer.
REQ-049 rst=1 during ACCESS -> all outputs 0 next cycle, no ready pulse, next en transfer completes normally.
